// File: rtl/scm_1row_access_ctrl.sv
// ============================================================================
// scm_1row_access_ctrl
//
// Access controller for the single-row latch SCM. One write stream and
// N_READ read streams are turned into WriteEnable / WriteData / ReadEnable
// controls for the latch row. Read responses come back registered, one cycle
// after the grant.
//
// No read is served from the latch in the cycle after a granted write, while
// the new data is still landing. A small streak counter stops a long run of
// back-to-back writes from starving pending readers.
//
// Optional feature, selected by the macro SCM_1ROW_BYPASS_EN:
//   defined   - reads are granted during COMMIT and answered from a copy of
//               the write data taken at write grant (the SCM is not read).
//   undefined - reads are held off during COMMIT; no copy register exists.
//
// Parameters
//   DATA_WIDTH    row width in bits
//   N_READ        number of read ports (1..8)
//   MAX_WR_BURST  granted writes allowed while a read is pending (1..15)
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   wr_req_i     write request (level, held until granted)
//   wr_data_i    write data
//   wr_gnt_o     write accepted this cycle
//   rd_req_i     read request per port (level, held until granted)
//   rd_gnt_o     read accepted this cycle, per port
//   rd_rvalid_o  one-cycle response pulse per grant
//   rd_rdata_o   registered response data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   scm_we_o     SCM WriteEnable
//   scm_wdata_o  SCM WriteData
//   scm_re_o     SCM ReadEnable, per port
//   scm_rdata_i  SCM ReadData, per port
// ============================================================================
module scm_1row_access_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int N_READ       = 2,
    parameter int MAX_WR_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_req_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    output logic                         wr_gnt_o,
    input  logic [N_READ-1:0]            rd_req_i,
    output logic [N_READ-1:0]            rd_gnt_o,
    output logic [N_READ-1:0]            rd_rvalid_o,
    output logic [N_READ*DATA_WIDTH-1:0] rd_rdata_o,
    output logic                         scm_we_o,
    output logic [DATA_WIDTH-1:0]        scm_wdata_o,
    output logic [N_READ-1:0]            scm_re_o,
    input  logic [N_READ*DATA_WIDTH-1:0] scm_rdata_i
);

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [3:0]                  r_wr_streak;
    logic [3:0]                  w_wr_streak_nxt;
    logic                        r_row_valid;
    logic [N_READ-1:0]           r_rd_rvalid;
    logic [N_READ*DATA_WIDTH-1:0] r_rd_rdata;

    logic                        w_rd_pending;
    logic                        w_throttle;
    logic                        w_wr_gnt;
    logic [N_READ-1:0]           w_rd_gnt;
    logic [N_READ-1:0]           w_scm_re;

`ifdef SCM_1ROW_BYPASS_EN
    // Copy of the last granted write, used to answer reads during COMMIT.
    logic [DATA_WIDTH-1:0]       r_wbuf;
    logic                        w_bypass_rd;
`endif

    assign w_rd_pending = |rd_req_i;
    assign w_throttle   = (r_wr_streak == 4'(MAX_WR_BURST));

    // Grant decision and next state. All grants stay low while rst_n is
    // asserted, whatever the requests are doing.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_gnt    = 1'b0;
        w_rd_gnt    = '0;
        w_scm_re    = '0;
`ifdef SCM_1ROW_BYPASS_EN
        w_bypass_rd = 1'b0;
`endif
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (wr_req_i && !w_throttle) begin
                        w_wr_gnt    = 1'b1;
                        w_state_nxt = COMMIT;
                    end else begin
                        w_rd_gnt = rd_req_i;
                        w_scm_re = rd_req_i;
                    end
                end
                COMMIT: begin
                    // The latch is transparent this cycle; the SCM is never
                    // read here.
                    w_state_nxt = IDLE;
`ifdef SCM_1ROW_BYPASS_EN
                    w_rd_gnt    = rd_req_i;
                    w_bypass_rd = 1'b1;
`endif
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // The streak only grows while a reader is waiting. It restarts once any
    // reader gets through or nobody is waiting any more.
    always_comb begin
        w_wr_streak_nxt = r_wr_streak;
        if ((|w_rd_gnt) || !w_rd_pending) begin
            w_wr_streak_nxt = 4'd0;
        end else if (w_wr_gnt) begin
            w_wr_streak_nxt = r_wr_streak + 4'd1;
        end
    end

    // State, throttle, row validity and the registered read responses. Until
    // the row has been written once, its content is undefined, so reads
    // return zero instead of the SCM output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wr_streak <= 4'd0;
            r_row_valid <= 1'b0;
            r_rd_rvalid <= '0;
            r_rd_rdata  <= '0;
`ifdef SCM_1ROW_BYPASS_EN
            r_wbuf      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_wr_streak <= w_wr_streak_nxt;
            r_rd_rvalid <= w_rd_gnt;
            if (w_wr_gnt) begin
                r_row_valid <= 1'b1;
`ifdef SCM_1ROW_BYPASS_EN
                r_wbuf      <= wr_data_i;
`endif
            end
            for (int i = 0; i < N_READ; i++) begin
                if (w_rd_gnt[i]) begin
`ifdef SCM_1ROW_BYPASS_EN
                    if (w_bypass_rd) begin
                        r_rd_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= r_wbuf;
                    end else
`endif
                    if (r_row_valid) begin
                        r_rd_rdata[i*DATA_WIDTH +: DATA_WIDTH] <=
                            scm_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        r_rd_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
                    end
                end
            end
        end
    end

    assign wr_gnt_o    = w_wr_gnt;
    assign rd_gnt_o    = w_rd_gnt;
    assign scm_we_o    = w_wr_gnt;
    assign scm_wdata_o = w_wr_gnt ? wr_data_i : '0;
    assign scm_re_o    = w_scm_re;
    assign rd_rvalid_o = r_rd_rvalid;
    assign rd_rdata_o  = r_rd_rdata;

endmodule

// File: tb/tb_scm_1row_access_ctrl.sv
// ============================================================================
// tb_scm_1row_access_ctrl
//
// Directed bench for scm_1row_access_ctrl with default parameters
// (DATA_WIDTH=32, N_READ=2, MAX_WR_BURST=4). A tiny latch-row model sits on
// the SCM side. Ports that are not read-enabled see a junk pattern, so any
// response that did not come through a proper SCM read stands out.
// Inputs change just after the falling edge. Outputs are sampled 2 ns later,
// well before the next rising edge.
// ============================================================================
module tb_scm_1row_access_ctrl;

   localparam int Dw = 32;
   localparam int Nr = 2;
`ifdef SCM_1ROW_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             wrReq;
   logic [Dw-1:0]    wrData;
   logic             wrGnt;
   logic [Nr-1:0]    rdReq;
   logic [Nr-1:0]    rdGnt;
   logic [Nr-1:0]    rdRvalid;
   logic [Nr*Dw-1:0] rdRdata;
   logic             scmWe;
   logic [Dw-1:0]    scmWdata;
   logic [Nr-1:0]    scmRe;
   logic [Nr*Dw-1:0] scmRdata;

   logic [Dw-1:0]    scmRow;
   int               nCompared;
   int               nMismatched;

   scm_1row_access_ctrl #(
      .DATA_WIDTH   (Dw),
      .N_READ       (Nr),
      .MAX_WR_BURST (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_req_i    (wrReq),
      .wr_data_i   (wrData),
      .wr_gnt_o    (wrGnt),
      .rd_req_i    (rdReq),
      .rd_gnt_o    (rdGnt),
      .rd_rvalid_o (rdRvalid),
      .rd_rdata_o  (rdRdata),
      .scm_we_o    (scmWe),
      .scm_wdata_o (scmWdata),
      .scm_re_o    (scmRe),
      .scm_rdata_i (scmRdata)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Latch row model. It starts with a non-zero pattern, so "row not yet
   // written" responses must really come back as zero.
   initial scmRow = 32'hCAFE_F00D;
   always @(posedge clk) begin
      if (scmWe) scmRow <= scmWdata;
   end

   // Read data presented to the controller. Ports that are not enabled see
   // junk.
   always_comb begin
      scmRdata = '0;
      for (int i = 0; i < Nr; i++) begin
         scmRdata[i*Dw +: Dw] = scmRe[i] ? scmRow : (32'hBAD0_0000 + 32'(i));
      end
   end

   // Safety net in case the run ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic          rstN;
      logic          wrReq;
      logic [Dw-1:0] wrData;
      logic [Nr-1:0] rdReq;
      logic          expWrGnt;
      logic [Nr-1:0] expRdGnt;
      logic [Nr-1:0] expRe;
      logic [Nr-1:0] expRvalid;
      logic [Dw-1:0] expRdata0;
      logic [Dw-1:0] expRdata1;
   } vec_t;

   vec_t vecs[15];

   // Drive one cycle of inputs just after the falling edge, then settle.
   task automatic applyStimulus(input logic r, input logic w,
                                input logic [Dw-1:0] d, input logic [Nr-1:0] rq);
      @(negedge clk);
      rst_n  = r;
      wrReq  = w;
      wrData = d;
      rdReq  = rq;
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic w, input logic [Dw-1:0] d,
                               input logic [Nr-1:0] rq, input logic eW,
                               input logic [Nr-1:0] eG, input logic [Nr-1:0] eRe,
                               input logic [Nr-1:0] eV, input logic [Dw-1:0] eD0,
                               input logic [Dw-1:0] eD1);
      vec_t v;
      v.rstN = r; v.wrReq = w; v.wrData = d; v.rdReq = rq;
      v.expWrGnt = eW; v.expRdGnt = eG; v.expRe = eRe; v.expRvalid = eV;
      v.expRdata0 = eD0; v.expRdata1 = eD1;
      return v;
   endfunction

   initial begin
      nCompared   = 0;
      nMismatched = 0;

      // Each row is one cycle: inputs first, then the expected outputs.
      //         rst   wr    data            rdReq  wGnt  rdGnt               re     rvalid              d0            d1
      vecs[0]  = mk(1'b0, 1'b1, 32'h1111_1111, 2'b11, 1'b0, 2'b00,              2'b00, 2'b00,              32'h0,        32'h0);
      vecs[1]  = mk(1'b1, 1'b0, 32'h0,         2'b01, 1'b0, 2'b01,              2'b01, 2'b00,              32'h0,        32'h0);
      vecs[2]  = mk(1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00,              2'b00, 2'b01,              32'h0,        32'h0);
      vecs[3]  = mk(1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1, 2'b00,              2'b00, 2'b00,              32'h0,        32'h0);
      vecs[4]  = mk(1'b1, 1'b0, 32'h0,         2'b10, 1'b0, Byp ? 2'b10 : 2'b00, 2'b00, 2'b00,             32'h0,        32'h0);
      vecs[5]  = mk(1'b1, 1'b0, 32'h0,         2'b10, 1'b0, 2'b10,              2'b10, Byp ? 2'b10 : 2'b00, 32'h0,       32'hDEAD_BEEF);
      vecs[6]  = mk(1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00,              2'b00, 2'b10,              32'h0,        32'hDEAD_BEEF);
      vecs[7]  = mk(1'b1, 1'b0, 32'h0,         2'b11, 1'b0, 2'b11,              2'b11, 2'b00,              32'h0,        32'h0);
      vecs[8]  = mk(1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00,              2'b00, 2'b11,              32'hDEAD_BEEF, 32'hDEAD_BEEF);
      vecs[9]  = mk(1'b1, 1'b1, 32'h0A0B_0C0D, 2'b00, 1'b1, 2'b00,              2'b00, 2'b00,              32'h0,        32'h0);
      vecs[10] = mk(1'b1, 1'b1, 32'h0000_0055, 2'b00, 1'b0, 2'b00,              2'b00, 2'b00,              32'h0,        32'h0);
      vecs[11] = mk(1'b1, 1'b1, 32'h0000_0055, 2'b00, 1'b1, 2'b00,              2'b00, 2'b00,              32'h0,        32'h0);
      vecs[12] = mk(1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00,              2'b00, 2'b00,              32'h0,        32'h0);
      vecs[13] = mk(1'b1, 1'b0, 32'h0,         2'b11, 1'b0, 2'b11,              2'b11, 2'b00,              32'h0,        32'h0);
      vecs[14] = mk(1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00,              2'b00, 2'b11,              32'h0000_0055, 32'h0000_0055);

      // Hold reset for two edges so every register holds a known value.
      rst_n = 1'b0; wrReq = 1'b0; wrData = '0; rdReq = '0;
      repeat (2) @(posedge clk);

      for (int k = 0; k < 15; k++) begin
         applyStimulus(vecs[k].rstN, vecs[k].wrReq, vecs[k].wrData, vecs[k].rdReq);
         checkOutput($sformatf("v%0d.wr_gnt", k), 64'(wrGnt), 64'(vecs[k].expWrGnt));
         checkOutput($sformatf("v%0d.scm_we", k), 64'(scmWe), 64'(vecs[k].expWrGnt));
         checkOutput($sformatf("v%0d.rd_gnt", k), 64'(rdGnt), 64'(vecs[k].expRdGnt));
         checkOutput($sformatf("v%0d.scm_re", k), 64'(scmRe), 64'(vecs[k].expRe));
         checkOutput($sformatf("v%0d.rvalid", k), 64'(rdRvalid), 64'(vecs[k].expRvalid));
         if (vecs[k].expWrGnt)
            checkOutput($sformatf("v%0d.scm_wdata", k), 64'(scmWdata), 64'(vecs[k].wrData));
         if (vecs[k].expRvalid[0] || !vecs[k].rstN)
            checkOutput($sformatf("v%0d.rdata0", k), 64'(rdRdata[0 +: Dw]), 64'(vecs[k].expRdata0));
         if (vecs[k].expRvalid[1] || !vecs[k].rstN)
            checkOutput($sformatf("v%0d.rdata1", k), 64'(rdRdata[Dw +: Dw]), 64'(vecs[k].expRdata1));
      end

`ifndef SCM_1ROW_BYPASS_EN
      // Write burst against a pending reader on port 0. Writes land at 0, 2,
      // 4 and 6. At 8 the streak is exhausted, so the read wins. Writing
      // resumes at 9, and the reader sees the value written at 6.
      for (int c = 0; c <= 10; c++) begin
         logic          expW;
         logic [Nr-1:0] expG;
         logic [Nr-1:0] rq;
         rq   = (c <= 8) ? 2'b01 : 2'b00;
         expW = (c == 0) || (c == 2) || (c == 4) || (c == 6) || (c == 9);
         expG = (c == 8) ? 2'b01 : 2'b00;
         applyStimulus(1'b1, 1'b1, 32'(c), rq);
         checkOutput($sformatf("burst%0d.wr_gnt", c), 64'(wrGnt), 64'(expW));
         checkOutput($sformatf("burst%0d.rd_gnt", c), 64'(rdGnt), 64'(expG));
         if (c == 9) begin
            checkOutput("burst9.rvalid", 64'(rdRvalid), 64'(2'b01));
            checkOutput("burst9.rdata0", 64'(rdRdata[0 +: Dw]), 64'(32'd6));
         end
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 2'b00);
`endif

      // Reset lands during COMMIT. The write is lost, every output drops to
      // its reset value, and the next read reports an unwritten row.
      applyStimulus(1'b1, 1'b1, 32'h1234_5678, 2'b00);
      checkOutput("rstc.wr_gnt", 64'(wrGnt), 64'(1'b1));
      applyStimulus(1'b0, 1'b1, 32'h1234_5678, 2'b01);
      checkOutput("rstc.gnt_in_reset", 64'({wrGnt, rdGnt}), 64'(3'b000));
      applyStimulus(1'b1, 1'b0, 32'h0, 2'b00);
      checkOutput("rstc.outs", 64'({wrGnt, rdGnt, rdRvalid, scmWe, scmRe}), 64'(0));
      checkOutput("rstc.rdata", 64'(rdRdata), 64'(0));
      checkOutput("rstc.wdata", 64'(scmWdata), 64'(0));
      applyStimulus(1'b1, 1'b0, 32'h0, 2'b01);
      checkOutput("rstc.rd_gnt", 64'(rdGnt), 64'(2'b01));
      applyStimulus(1'b1, 1'b0, 32'h0, 2'b00);
      checkOutput("rstc.rvalid", 64'(rdRvalid), 64'(2'b01));
      checkOutput("rstc.rdata0", 64'(rdRdata[0 +: Dw]), 64'(32'h0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/scm_1row_access_ctrl.md
# scm_1row_access_ctrl

Access controller for the single-row latch SCM: turns one valid/grant write stream and N_READ valid/grant read streams into the SCM's `WriteEnable`/`WriteData`/`ReadEnable` controls, and returns registered read responses. Sits between cluster-side masters and the 1-row latch register file. Guarantees no read is served from the row while a write is landing in the latch. Also bounds write starvation of readers.

## Interface
- `DATA_WIDTH`, 32: row width in bits
- `N_READ`, 2: number of read ports, 1..8
- `MAX_WR_BURST`, 4: consecutive granted writes allowed while any read is pending, 1..15

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `wr_req_i`  in  1  write request
- `wr_data_i`  in  DATA_WIDTH  write data, valid with `wr_req_i`
- `wr_gnt_o`  out  1  write accepted this cycle
- `rd_req_i`  in  N_READ  read request per port
- `rd_gnt_o`  out  N_READ  read accepted this cycle, per port
- `rd_rvalid_o`  out  N_READ  read response valid, per port
- `rd_rdata_o`  out  N_READ×DATA_WIDTH  read response data
- `scm_we_o`  out  1  to SCM `WriteEnable`
- `scm_wdata_o`  out  DATA_WIDTH  to SCM `WriteData`
- `scm_re_o`  out  N_READ  to SCM `ReadEnable`
- `scm_rdata_i`  in  N_READ×DATA_WIDTH  from SCM `ReadData`

## Operation
- FSM states: IDLE, COMMIT.
- IDLE, `wr_req_i`=1 and not throttled: `wr_gnt_o`=1, `scm_we_o`=1, `scm_wdata_o`=`wr_data_i` (combinational). All `rd_gnt_o`=0. Next state COMMIT.
- IDLE, no granted write: `rd_gnt_o`=`rd_req_i`, `scm_re_o`=`rd_req_i`. All ports served in parallel; there is no read arbitration. Stay in IDLE.
- COMMIT: one cycle. `wr_gnt_o`=0, `scm_we_o`=0. Reads are handled per the Configuration section. Next state IDLE.
- Throttle: 4-bit `wr_streak` counts granted writes while |`rd_req_i`.
  - Reset to 0 on any cycle with reads granted, or when no read is pending.
  - When `wr_streak`==MAX_WR_BURST, writes are refused in IDLE. Pending reads are granted and `wr_streak` clears.
- `row_valid` flag: 0 at reset, set on the first granted write. While `row_valid`=0, granted reads return data 0 and ignore `scm_rdata_i`.
- Reset mid-COMMIT: FSM goes to IDLE, `row_valid`=0, and the landing write is considered lost.

## Timing
- Write: granted in cycle N; row holds the new data from cycle N+1. Maximum write throughput is 1 per 2 cycles.
- Read: granted in cycle N; `rd_rvalid_o[i]`=1 and `rd_rdata_o[i]` in cycle N+1 (registered capture of `scm_rdata_i[i]`). `rd_rvalid_o` is a 1-cycle pulse per grant.
- Requests are level; a non-granted request must be held stable by the master until granted.
- Reset values: `wr_gnt_o`=0, `rd_gnt_o`=0, `rd_rvalid_o`=0, `rd_rdata_o`=0, `scm_we_o`=0, `scm_wdata_o`=0, `scm_re_o`=0; FSM=IDLE, `wr_streak`=0.
- In reset, grants are forced to 0 regardless of requests.

## Configuration
- `SCM_1ROW_BYPASS_EN` defined:
  - Reads in COMMIT are granted, with `scm_re_o`=0.
  - The response in the next cycle carries the write data held in an internal register captured at write grant, not the SCM output.
  - `row_valid` is treated as 1 for these reads.
- `SCM_1ROW_BYPASS_EN` undefined:
  - In COMMIT, `rd_gnt_o`=0 and `scm_re_o`=0.
  - Reads wait to IDLE of cycle N+2; no forwarding register is instantiated.

## Test plan
- Reset release, read port 0 requests immediately → gnt at cycle 0, `rd_rvalid_o[0]`=1 with data 0x0 at cycle 1 (`row_valid`=0).
- Write 0xDEADBEEF at cycle N, port 1 reads continuously → no port 1 grant at N or N+1 (bypass off); grant at N+2; data 0xDEADBEEF at N+3. With `SCM_1ROW_BYPASS_EN`: grant at N+1, data 0xDEADBEEF at N+2.
- Both read ports request in the same IDLE cycle → both granted; both `rd_rvalid_o` pulse next cycle with identical row data.
- Continuous writes with port 0 read pending, MAX_WR_BURST=4 → 4 write grants at cycles 0,2,4,6; cycle 8 read granted, write refused; write resumes at cycle 9.
- Assert `rst_n`=0 in COMMIT after writing 0x12345678 → outputs at reset values next cycle; a subsequent read returns 0x0.
